trap_event_gen: RTL and testbench

Producer side of the difftest trap-event channel. It watches the commit stage and keeps 64-bit cycle and retired-instruction counters. It detects a good/bad trap, a simulation timeout or a WFI commit, and drives the trap-event record (enable plus payload) consumed by the difftest trap-event sink. It sits beside the commit/writeback stage, and its `trapped` output is the core's halt request.

---
 rtl/trap_event_gen.sv | 116 +++++++++++
 tb/tb_trap_event_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : trap_event_gen
// Description : Producer side of the difftest trap-event channel. Tracks
//               64-bit cycle and retired-instruction counters, detects a
//               good/bad trap, a simulation timeout or a WFI commit, and
//               drives the trap-event record plus a sticky halt request.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_event_gen #(
    parameter logic [7:0]  COREID  = 8'd0,
    parameter logic [63:0] TIMEOUT = 64'd0
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic        commit_is_trap,
    input  logic        commit_is_wfi,
    input  logic [63:0] trap_code,
    output logic        te_enable,
    output logic        te_hasTrap,
    output logic [63:0] te_cycleCnt,
    output logic [63:0] te_instrCnt,
    output logic        te_hasWFI,
    output logic [63:0] te_code,
    output logic [63:0] te_pc,
    output logic [7:0]  te_coreid,
    output logic        trapped
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [63:0] TIMEOUT_CODE = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [1:0]  state;
    logic [63:0] cycle_q;
    logic [63:0] instr_q;
    logic [63:0] code_q;
    logic [63:0] pc_q;
    logic [63:0] last_pc;
    logic        wfi_q;

    logic [63:0] cycle_next;
    logic        trap_hit;
    logic        timeout_hit;

    // Trap/timeout detection; the timeout compares against the incremented count
    always_comb begin
        cycle_next  = cycle_q + 64'd1;
        trap_hit    = commit_valid && commit_is_trap;
        timeout_hit = (TIMEOUT != 64'd0) && (cycle_next == TIMEOUT);
    end

    // Run-state machine with counters, WFI flag and report payload capture
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cycle_q <= 64'd0;
            instr_q <= 64'd0;
            code_q  <= 64'd0;
            pc_q    <= 64'd0;
            last_pc <= 64'd0;
            wfi_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    cycle_q <= cycle_next;
                    if (commit_valid) begin
                        instr_q <= instr_q + 64'd1;
                        last_pc <= commit_pc;
                        // Set by a WFI commit, cleared by any other commit
                        wfi_q   <= commit_is_wfi;
                    end
                    // Trap has priority over a coincident timeout
                    if (trap_hit) begin
                        state  <= ST_REPORT;
                        code_q <= trap_code;
                        pc_q   <= commit_pc;
                    end else if (timeout_hit) begin
                        state  <= ST_REPORT;
                        code_q <= TIMEOUT_CODE;
                        pc_q   <= commit_valid ? commit_pc : last_pc;
                    end
                end
                ST_REPORT: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_DONE;
                end
            endcase
        end
    end

    // Record outputs decoded straight from registered state
    always_comb begin
        te_enable   = (state == ST_RUN) || (state == ST_REPORT);
        te_hasTrap  = (state == ST_REPORT);
        te_cycleCnt = cycle_q;
        te_instrCnt = instr_q;
        te_hasWFI   = wfi_q;
        te_code     = code_q;
        te_pc       = pc_q;
        te_coreid   = COREID;
        trapped     = (state == ST_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_event_gen
// Description : Self-checking bench for trap_event_gen. Three instances
//               (no timeout, TIMEOUT=16, TIMEOUT=8) share the commit bus and
//               each has its own reset. A behavioural model is compared on
//               every falling edge; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_event_gen;

    logic        clock;
    logic        rst_n [3];
    logic        cv;
    logic [63:0] cpc;
    logic        ctrap;
    logic        cwfi;
    logic [63:0] ccode;

    logic        en   [3];
    logic        ht   [3];
    logic [63:0] cyc  [3];
    logic [63:0] ins  [3];
    logic        wfi  [3];
    logic [63:0] code [3];
    logic [63:0] pc   [3];
    logic [7:0]  cid  [3];
    logic        trp  [3];

    int tests = 0;
    int fails = 0;

    trap_event_gen #(.COREID(8'h00), .TIMEOUT(64'd0)) u_dut0 (
        .clock(clock), .rst_n(rst_n[0]), .commit_valid(cv), .commit_pc(cpc),
        .commit_is_trap(ctrap), .commit_is_wfi(cwfi), .trap_code(ccode),
        .te_enable(en[0]), .te_hasTrap(ht[0]), .te_cycleCnt(cyc[0]),
        .te_instrCnt(ins[0]), .te_hasWFI(wfi[0]), .te_code(code[0]),
        .te_pc(pc[0]), .te_coreid(cid[0]), .trapped(trp[0]));

    trap_event_gen #(.COREID(8'h11), .TIMEOUT(64'd16)) u_dut1 (
        .clock(clock), .rst_n(rst_n[1]), .commit_valid(cv), .commit_pc(cpc),
        .commit_is_trap(ctrap), .commit_is_wfi(cwfi), .trap_code(ccode),
        .te_enable(en[1]), .te_hasTrap(ht[1]), .te_cycleCnt(cyc[1]),
        .te_instrCnt(ins[1]), .te_hasWFI(wfi[1]), .te_code(code[1]),
        .te_pc(pc[1]), .te_coreid(cid[1]), .trapped(trp[1]));

    trap_event_gen #(.COREID(8'h22), .TIMEOUT(64'd8)) u_dut2 (
        .clock(clock), .rst_n(rst_n[2]), .commit_valid(cv), .commit_pc(cpc),
        .commit_is_trap(ctrap), .commit_is_wfi(cwfi), .trap_code(ccode),
        .te_enable(en[2]), .te_hasTrap(ht[2]), .te_cycleCnt(cyc[2]),
        .te_instrCnt(ins[2]), .te_hasWFI(wfi[2]), .te_code(code[2]),
        .te_pc(pc[2]), .te_coreid(cid[2]), .trapped(trp[2]));

    // Free-running clock, 10 time units per period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [63:0] timeout_of(input int k);
        case (k)
            1:       return 64'd16;
            2:       return 64'd8;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [7:0] coreid_of(input int k);
        case (k)
            1:       return 8'h11;
            2:       return 8'h22;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for first edge, 1 running, 2 reporting, 3 halted
    int          m_phase [3];
    logic [63:0] m_cyc   [3];
    logic [63:0] m_ins   [3];
    logic [63:0] m_code  [3];
    logic [63:0] m_pc    [3];
    logic [63:0] m_last  [3];
    logic        m_wfi   [3];

    // Model advances on each rising edge from inputs stable since the prior edge
    always @(posedge clock) begin : model
        for (int k = 0; k < 3; k++) begin
            if (!rst_n[k]) begin
                m_phase[k] = 0;
                m_cyc[k] = 0; m_ins[k] = 0; m_code[k] = 0;
                m_pc[k] = 0;  m_last[k] = 0; m_wfi[k] = 1'b0;
            end else if (m_phase[k] == 0) begin
                m_phase[k] = 1;
            end else if (m_phase[k] == 1) begin
                m_cyc[k] = m_cyc[k] + 1;
                if (cv) begin
                    m_ins[k]  = m_ins[k] + 1;
                    m_last[k] = cpc;
                    m_wfi[k]  = cwfi;
                end
                if (cv && ctrap) begin
                    m_phase[k] = 2; m_code[k] = ccode; m_pc[k] = cpc;
                end else if (timeout_of(k) != 0 && m_cyc[k] == timeout_of(k)) begin
                    m_phase[k] = 2; m_code[k] = '1; m_pc[k] = m_last[k];
                end
            end else begin
                m_phase[k] = 3;
            end
        end
    end

    // Every falling edge, every instance is compared with the model
    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n[k]) begin
                chk($sformatf("rst_en%0d", k),   64'(en[k]),  64'd0);
                chk($sformatf("rst_trp%0d", k),  64'(trp[k]), 64'd0);
                chk($sformatf("rst_cyc%0d", k),  cyc[k],      64'd0);
                chk($sformatf("rst_ins%0d", k),  ins[k],      64'd0);
                chk($sformatf("rst_code%0d", k), code[k],     64'd0);
                chk($sformatf("rst_pc%0d", k),   pc[k],       64'd0);
            end else begin
                chk($sformatf("en%0d", k),   64'(en[k]),  64'(m_phase[k] == 1 || m_phase[k] == 2));
                chk($sformatf("ht%0d", k),   64'(ht[k]),  64'(m_phase[k] == 2));
                chk($sformatf("trp%0d", k),  64'(trp[k]), 64'(m_phase[k] == 3));
                chk($sformatf("cyc%0d", k),  cyc[k],      m_cyc[k]);
                chk($sformatf("ins%0d", k),  ins[k],      m_ins[k]);
                chk($sformatf("wfi%0d", k),  64'(wfi[k]), 64'(m_wfi[k]));
                chk($sformatf("code%0d", k), code[k],     m_code[k]);
                chk($sformatf("pc%0d", k),   pc[k],       m_pc[k]);
            end
            chk($sformatf("cid%0d", k), 64'(cid[k]), 64'(coreid_of(k)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] p, input logic t,
                         input logic w, input logic [63:0] c);
        cv = v; cpc = p; ctrap = t; cwfi = w; ccode = c;
    endtask

    task automatic idle_bus();
        drive(1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
        idle_bus();
        repeat (3) step();
        chk("lit_rst_en", 64'(en[0]), 64'd0);

        // Reset then idle: counter reads 0..4 over five edges
        rst_n[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("lit_idle_cyc%0d", i), cyc[0], 64'(i));
            chk("lit_idle_en", 64'(en[0]), 64'd1);
            chk("lit_idle_ins", ins[0], 64'd0);
        end

        // Good trap after 10 commits
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0, 64'd0);
            step();
        end
        drive(1'b1, 64'h8000_0028, 1'b1, 1'b0, 64'd0);
        step();
        idle_bus();
        chk("lit_good_ht",   64'(ht[0]), 64'd1);
        chk("lit_good_en",   64'(en[0]), 64'd1);
        chk("lit_good_ins",  ins[0],     64'd11);
        chk("lit_good_pc",   pc[0],      64'h8000_0028);
        chk("lit_good_code", code[0],    64'd0);
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom_range(1)), 64'($urandom), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 64'($urandom));
            step();
            chk("lit_done_trp", 64'(trp[0]), 64'd1);
            chk("lit_done_en",  64'(en[0]),  64'd0);
        end
        chk("lit_done_ins", ins[0], 64'd11);
        idle_bus();

        // Reset asserted during the REPORT cycle
        rst_n[0] = 1'b0;
        step();
        rst_n[0] = 1'b1;
        step();
        drive(1'b1, 64'h8000_0000, 1'b0, 1'b0, 64'd0);
        step();
        drive(1'b1, 64'h8000_0004, 1'b1, 1'b0, 64'd3);
        step();
        idle_bus();
        chk("lit_rr_ht", 64'(ht[0]), 64'd1);
        rst_n[0] = 1'b0;
        #1;
        chk("lit_rr_en",  64'(en[0]),  64'd0);
        chk("lit_rr_ht0", 64'(ht[0]),  64'd0);
        chk("lit_rr_cyc", cyc[0],      64'd0);
        chk("lit_rr_pc",  pc[0],       64'd0);
        chk("lit_rr_trp", 64'(trp[0]), 64'd0);
        step();
        rst_n[0] = 1'b1;
        step();
        chk("lit_rr_restart_cyc", cyc[0], 64'd0);
        chk("lit_rr_restart_en",  64'(en[0]), 64'd1);
        chk("lit_rr_restart_trp", 64'(trp[0]), 64'd0);

        // WFI sticks across commit-free cycles, drops on a non-WFI commit
        drive(1'b1, 64'h8000_0010, 1'b0, 1'b1, 64'd0);
        step();
        idle_bus();
        chk("lit_wfi_set", 64'(wfi[0]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lit_wfi_hold", 64'(wfi[0]), 64'd1);
        end
        drive(1'b1, 64'h8000_0014, 1'b0, 1'b0, 64'd0);
        step();
        idle_bus();
        chk("lit_wfi_clr", 64'(wfi[0]), 64'd0);
        rst_n[0] = 1'b0;

        // Timeout at 16 with the last commit on the timeout edge itself
        rst_n[1] = 1'b1;
        step();
        for (int e = 1; e <= 16; e++) begin
            if (e == 3)       drive(1'b1, 64'h8000_0040, 1'b0, 1'b0, 64'd0);
            else if (e == 16) drive(1'b1, 64'h8000_0100, 1'b0, 1'b0, 64'd0);
            else              idle_bus();
            step();
            if (e == 15) chk("lit_to_before", 64'(ht[1]), 64'd0);
        end
        idle_bus();
        chk("lit_to_ht",   64'(ht[1]), 64'd1);
        chk("lit_to_cyc",  cyc[1],     64'd16);
        chk("lit_to_code", code[1],    64'hFFFF_FFFF_FFFF_FFFF);
        chk("lit_to_pc",   pc[1],      64'h8000_0100);
        chk("lit_to_ins",  ins[1],     64'd2);
        step();
        chk("lit_to_trp", 64'(trp[1]), 64'd1);
        rst_n[1] = 1'b0;

        // Trap and timeout on the same edge: trap wins
        rst_n[2] = 1'b1;
        step();
        for (int e = 1; e <= 8; e++) begin
            if (e == 2)      drive(1'b1, 64'h8000_0020, 1'b0, 1'b0, 64'd0);
            else if (e == 8) drive(1'b1, 64'h8000_0200, 1'b1, 1'b0, 64'd5);
            else             idle_bus();
            step();
        end
        idle_bus();
        chk("lit_tt_ht",   64'(ht[2]), 64'd1);
        chk("lit_tt_code", code[2],    64'd5);
        chk("lit_tt_pc",   pc[2],      64'h8000_0200);
        chk("lit_tt_cyc",  cyc[2],     64'd8);
        chk("lit_tt_ins",  ins[2],     64'd2);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
